// File: rtl/uart_tx_core.sv
// UART transmit engine: 8 data bits, LSB first, 1 or 2 stop bits.
// Bit timing comes from a fractional (NCO) baud accumulator.
module uart_tx_core #(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_in,
    input  logic       strtx_in,
    input  logic [3:0] br_in,
    input  logic [7:0] clk_mhz_in,
    input  logic [7:0] txdata_in,
    output logic       tbusy_out,
    output logic       tx_done_out,
    output logic       uart_tx_out
);

    localparam int unsigned ACC_W   = 28;
    localparam int unsigned BAUD_W  = 20;
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned HZ_PER_MHZ = 1_000_000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [ACC_W-1:0]    freq_q, freq_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                strtx_prev_q, strtx_prev_d;
    logic                tx_q, tx_d;
    logic                tbusy_q, tbusy_d;
    logic                done_q, done_d;

    logic [BAUD_W-1:0]   baud_sel_c;
    logic [ACC_W-1:0]    freq_sel_c;
    logic [SUM_W-1:0]    sum_c;
    logic [IDX_W-1:0]    next_idx_c;
    logic                tick_c;
    logic                start_req_c;
    logic                accept_c;
    logic                last_stop_c;

    // Baud rate table; unused selector codes alias to 115200.
    always_comb begin : baud_lookup
        baud_sel_c = BAUD_W'(115200);
        case (br_in)
            4'd0:    baud_sel_c = BAUD_W'(1200);
            4'd1:    baud_sel_c = BAUD_W'(2400);
            4'd2:    baud_sel_c = BAUD_W'(4800);
            4'd3:    baud_sel_c = BAUD_W'(9600);
            4'd4:    baud_sel_c = BAUD_W'(19200);
            4'd5:    baud_sel_c = BAUD_W'(38400);
            4'd6:    baud_sel_c = BAUD_W'(57600);
            4'd7:    baud_sel_c = BAUD_W'(115200);
            4'd8:    baud_sel_c = BAUD_W'(230400);
            4'd9:    baud_sel_c = BAUD_W'(460800);
            4'd10:   baud_sel_c = BAUD_W'(921600);
            default: baud_sel_c = BAUD_W'(115200);
        endcase
    end

    // Accumulator step and request qualification.
    always_comb begin : tick_logic
        freq_sel_c  = ACC_W'(clk_mhz_in) * ACC_W'(HZ_PER_MHZ);
        sum_c       = SUM_W'(acc_q) + SUM_W'(baud_q);
        tick_c      = (sum_c >= SUM_W'(freq_q));
        next_idx_c  = bit_idx_q + IDX_W'(1);
        start_req_c = strtx_in & ~strtx_prev_q;
        accept_c    = start_req_c & en_in & (clk_mhz_in != 8'd0);
        last_stop_c = (stop_cnt_q == 1'(STOP_BITS - 1));
    end

    // Next-state and output decode.
    always_comb begin : next_state
        state_d      = state_q;
        acc_d        = acc_q;
        baud_d       = baud_q;
        freq_d       = freq_q;
        data_d       = data_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        strtx_prev_d = strtx_in;
        tx_d         = tx_q;
        tbusy_d      = tbusy_q;
        done_d       = 1'b0;

        if (state_q == ST_IDLE) begin
            if (accept_c) begin
                data_d    = txdata_in;
                baud_d    = baud_sel_c;
                freq_d    = freq_sel_c;
                acc_d     = '0;
                bit_idx_d = '0;
                state_d   = ST_START;
                tx_d      = 1'b0;
                tbusy_d   = 1'b1;
            end
        end else if (!en_in) begin
            // Abort: return to idle with the line released, no completion pulse.
            state_d = ST_IDLE;
            acc_d   = '0;
            tx_d    = 1'b1;
            tbusy_d = 1'b0;
        end else begin
            acc_d = tick_c ? ACC_W'(sum_c - SUM_W'(freq_q)) : ACC_W'(sum_c);
            if (tick_c) begin
                case (state_q)
                    ST_START: begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                        tx_d      = data_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end else begin
                            bit_idx_d = next_idx_c;
                            tx_d      = data_q[next_idx_c];
                        end
                    end
                    ST_STOP: begin
                        tx_d = 1'b1;
                        if (last_stop_c) begin
                            state_d = ST_IDLE;
                            tbusy_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            stop_cnt_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin : state_reg
        if (!rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            baud_q       <= '0;
            freq_q       <= '0;
            data_q       <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            strtx_prev_q <= 1'b0;
            tx_q         <= 1'b1;
            tbusy_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            baud_q       <= baud_d;
            freq_q       <= freq_d;
            data_q       <= data_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            strtx_prev_q <= strtx_prev_d;
            tx_q         <= tx_d;
            tbusy_q      <= tbusy_d;
            done_q       <= done_d;
        end
    end

    assign uart_tx_out = tx_q;
    assign tbusy_out   = tbusy_q;
    assign tx_done_out = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core against an arithmetic frame-timing model.
module tb_uart_tx_core;

    localparam int unsigned STOP_BITS = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_in;
    logic       strtx_in;
    logic [3:0] br_in;
    logic [7:0] clk_mhz_in;
    logic [7:0] txdata_in;
    logic       tbusy_out;
    logic       tx_done_out;
    logic       uart_tx_out;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_core #(.STOP_BITS(STOP_BITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_in       (en_in),
        .strtx_in    (strtx_in),
        .br_in       (br_in),
        .clk_mhz_in  (clk_mhz_in),
        .txdata_in   (txdata_in),
        .tbusy_out   (tbusy_out),
        .tx_done_out (tx_done_out),
        .uart_tx_out (uart_tx_out)
    );

    always #5 clk = ~clk;

    function automatic longint baud_of(input int sel);
        case (sel)
            0: return 1200;
            1: return 2400;
            2: return 4800;
            3: return 9600;
            4: return 19200;
            5: return 38400;
            6: return 57600;
            7: return 115200;
            8: return 230400;
            9: return 460800;
            10: return 921600;
            default: return 115200;
        endcase
    endfunction

    // Cycle (relative to the accept edge) at which the frame completes.
    function automatic longint frame_len(input longint b, input longint f);
        return ((9 + STOP_BITS) * f + b - 1) / b;
    endfunction

    // Expected line level after edge n: bit index is floor(n*BAUD/F).
    function automatic logic exp_line(input longint n, input logic [7:0] d,
                                      input longint b, input longint f);
        longint k;
        k = (n * b) / f;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[int'(k - 1)];
        return 1'b1;
    endfunction

    function automatic logic [2:0] exp_vec(input longint n, input logic [7:0] d,
                                           input longint b, input longint f,
                                           input longint len);
        return {exp_line(n, d, b, f), 1'(n < len), 1'(n == len)};
    endfunction

    // Produce a fresh 0->1 edge on strtx_in; returns just after the accept edge.
    task automatic kick();
        @(negedge clk); strtx_in = 1'b0;
        @(negedge clk); strtx_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        longint b, f, len;
        logic [2:0] e;
        rst = 1'b0; en_in = 1'b1; strtx_in = 1'b1; br_in = 4'd7;
        clk_mhz_in = 8'd1; txdata_in = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== 3'b100) begin
                n_err++;
                $display("FAIL reset cyc=%0d tx/busy/done got %b required 100", i,
                         {uart_tx_out, tbusy_out, tx_done_out});
            end
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        b = baud_of(7); f = 1_000_000; len = frame_len(b, f);
        for (int n = 0; n <= len + 3; n++) begin
            e = exp_vec(n, 8'hA3, b, f, len);
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                n_err++;
                $display("FAIL reset_release n=%0d tx/busy/done got %b required %b", n,
                         {uart_tx_out, tbusy_out, tx_done_out}, e);
            end
            @(posedge clk); #1;
        end
        strtx_in = 1'b0;
    endtask

    task automatic test_basic_frame();
        longint b, f, len;
        logic [2:0] e;
        en_in = 1'b1; clk_mhz_in = 8'd1; br_in = 4'd7; txdata_in = 8'h55;
        b = baud_of(7); f = 1_000_000; len = frame_len(b, f);
        kick();
        for (int n = 0; n <= len + 20; n++) begin
            e = exp_vec(n, 8'h55, b, f, len);
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                n_err++;
                $display("FAIL basic n=%0d tx/busy/done got %b required %b", n,
                         {uart_tx_out, tbusy_out, tx_done_out}, e);
            end
            if (n == 40) strtx_in = 1'b0;
            if (n == 41) strtx_in = 1'b1;
            @(posedge clk); #1;
        end
        strtx_in = 1'b0;
    endtask

    task automatic test_abort();
        longint b, f, len;
        logic [2:0] e;
        logic [7:0] d;
        en_in = 1'b1; clk_mhz_in = 8'd1; br_in = 4'd7;
        d = 8'($urandom); txdata_in = d;
        b = baud_of(7); f = 1_000_000; len = frame_len(b, f);
        kick();
        for (int n = 0; n <= 30; n++) begin
            e = exp_vec(n, d, b, f, len);
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                n_err++;
                $display("FAIL abort_pre n=%0d tx/busy/done got %b required %b", n,
                         {uart_tx_out, tbusy_out, tx_done_out}, e);
            end
            if (n == 30) en_in = 1'b0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== 3'b100) begin
                n_err++;
                $display("FAIL abort_idle i=%0d tx/busy/done got %b required 100", i,
                         {uart_tx_out, tbusy_out, tx_done_out});
            end
            @(posedge clk); #1;
        end
        en_in = 1'b1;
        d = 8'($urandom); txdata_in = d;
        kick();
        for (int n = 0; n <= len + 3; n++) begin
            e = exp_vec(n, d, b, f, len);
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                n_err++;
                $display("FAIL abort_restart n=%0d tx/busy/done got %b required %b", n,
                         {uart_tx_out, tbusy_out, tx_done_out}, e);
            end
            @(posedge clk); #1;
        end
        strtx_in = 1'b0;
    endtask

    task automatic test_disabled_clock();
        en_in = 1'b1; clk_mhz_in = 8'd0; br_in = 4'd7; txdata_in = 8'h0F;
        kick();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== 3'b100) begin
                n_err++;
                $display("FAIL clk0 i=%0d tx/busy/done got %b required 100", i,
                         {uart_tx_out, tbusy_out, tx_done_out});
            end
            if (i == 4) clk_mhz_in = 8'd1;
            @(posedge clk); #1;
        end
        strtx_in = 1'b0;
    endtask

    task automatic test_alias();
        longint b, f, len;
        logic [2:0] e;
        logic [7:0] d;
        en_in = 1'b1; clk_mhz_in = 8'd1; br_in = 4'd12;
        d = 8'($urandom); txdata_in = d;
        b = 115200; f = 1_000_000; len = frame_len(b, f);
        kick();
        for (int n = 0; n <= len + 3; n++) begin
            e = exp_vec(n, d, b, f, len);
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                n_err++;
                $display("FAIL alias n=%0d tx/busy/done got %b required %b", n,
                         {uart_tx_out, tbusy_out, tx_done_out}, e);
            end
            @(posedge clk); #1;
        end
        strtx_in = 1'b0;
    endtask

    task automatic test_latching();
        longint b, f, len;
        logic [2:0] e;
        logic [7:0] d;
        en_in = 1'b1; clk_mhz_in = 8'd1; br_in = 4'd7;
        d = 8'($urandom); txdata_in = d;
        b = baud_of(7); f = 1_000_000; len = frame_len(b, f);
        kick();
        for (int n = 0; n <= len + 3; n++) begin
            e = exp_vec(n, d, b, f, len);
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                n_err++;
                $display("FAIL latch n=%0d tx/busy/done got %b required %b", n,
                         {uart_tx_out, tbusy_out, tx_done_out}, e);
            end
            if (n == 5) begin
                br_in = 4'd0; txdata_in = ~d; clk_mhz_in = 8'd3;
            end
            @(posedge clk); #1;
        end
        clk_mhz_in = 8'd1;
        d = 8'($urandom); txdata_in = d;
        b = baud_of(0); len = frame_len(b, f);
        kick();
        for (int n = 0; n <= len + 3; n++) begin
            e = exp_vec(n, d, b, f, len);
            n_cmp++;
            if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                n_err++;
                $display("FAIL slow1200 n=%0d tx/busy/done got %b required %b", n,
                         {uart_tx_out, tbusy_out, tx_done_out}, e);
            end
            @(posedge clk); #1;
        end
        strtx_in = 1'b0;
    endtask

    task automatic test_random_frames();
        longint b, f, len;
        logic [2:0] e;
        logic [7:0] d;
        int sel;
        for (int k = 0; k < 6; k++) begin
            en_in = 1'b1;
            sel = int'($urandom_range(3, 15));
            br_in = 4'(sel);
            clk_mhz_in = 8'($urandom_range(1, 2));
            d = 8'($urandom); txdata_in = d;
            b = baud_of(sel); f = longint'(clk_mhz_in) * 1_000_000; len = frame_len(b, f);
            kick();
            for (int n = 0; n <= len + 2; n++) begin
                e = exp_vec(n, d, b, f, len);
                n_cmp++;
                if ({uart_tx_out, tbusy_out, tx_done_out} !== e) begin
                    n_err++;
                    $display("FAIL random k=%0d br=%0d n=%0d tx/busy/done got %b required %b",
                             k, sel, n, {uart_tx_out, tbusy_out, tx_done_out}, e);
                end
                if (n == 3) begin
                    br_in = 4'($urandom); clk_mhz_in = 8'($urandom); txdata_in = 8'($urandom);
                end
                @(posedge clk); #1;
            end
            strtx_in = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; en_in = 1'b0; strtx_in = 1'b0; br_in = 4'd0;
        clk_mhz_in = 8'd0; txdata_in = 8'd0;
        test_reset();
        test_basic_frame();
        test_abort();
        test_disabled_clock();
        test_alias();
        test_latching();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
